// File: rtl/c2c_resp.sv
// c2c_resp: target-side responder for the c2c request bus.
// Word-addressed local memory with byte-enable writes and a fixed-latency,
// fully pipelined read return path. No backpressure: every req is taken.
//
// Optional statistics (define C2C_RESP_STATS_EN): per-layer write/read
// counters, captured into wr_cnt_q/rd_cnt_q on each layer_done pulse.
// With the macro undefined no counters exist and both outputs read 0.
//
// Ports:
//   clk        clock, all logic on its rising edge
//   rst        synchronous active-high reset (memory contents survive it)
//   req        request strobe, one transaction per asserted cycle
//   addr       byte address (low log2(STRB_WIDTH) bits ignored)
//   data       write data
//   be         write byte enables (ignored for reads)
//   we         1 = write, 0 = read
//   layer_done single-cycle end-of-layer pulse (statistics only)
//   r_valid    read data valid, one pulse per read, RD_LAT after req
//   r_data     read data, holds its last value while r_valid = 0
//   r_err      out-of-range read flag, qualified by r_valid
//   w_err      one-cycle pulse the cycle after an out-of-range write
//   wr_cnt_q   writes counted in the last completed layer
//   rd_cnt_q   reads counted in the last completed layer

module c2c_resp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH      = 1024,
    parameter int RD_LAT     = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [STRB_WIDTH-1:0] be,
    input  logic                  we,
    input  logic                  layer_done,
    output logic                  r_valid,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_err,
    output logic                  w_err,
    output logic [CNT_WIDTH-1:0]  wr_cnt_q,
    output logic [CNT_WIDTH-1:0]  rd_cnt_q
);

    localparam int SHIFT = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(DEPTH);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] idx;
    logic [IDX_W-1:0]      idx_lo;
    logic                  in_range;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  any_be;

    // The range check uses the whole shifted address so that large
    // addresses never alias onto low words.
    assign idx      = addr >> SHIFT;
    assign idx_lo   = idx[IDX_W-1:0];
    assign in_range = (idx < DEPTH_W);
    assign any_be   = |be;

    // A request in the same cycle as reset is ignored.
    assign wr_acc = req & we & ~rst;
    assign rd_acc = req & ~we & ~rst;

    // ------------------------------------------------------------------
    // Storage (not reset: contents persist across rst)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;

    // Sampled before this edge's write lands, so a read and a later write
    // to the same word return the old value.
    assign rd_word = in_range ? mem[idx_lo] : '0;

    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            for (int k = 0; k < STRB_WIDTH; k++) begin
                if (be[k]) begin
                    mem[idx_lo][8*k +: 8] <= data[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Write error pulse
    // ------------------------------------------------------------------
    // A write with no byte lanes enabled is a no-op and never flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_err <= 1'b0;
        end else begin
            w_err <= wr_acc & ~in_range & any_be;
        end
    end

    // ------------------------------------------------------------------
    // Read return pipeline
    // ------------------------------------------------------------------
    // Stage data only advances behind a valid, so the last stage (which
    // drives r_data/r_err) holds the most recent read while idle.
    logic [RD_LAT-1:0]     pv;
    logic [DATA_WIDTH-1:0] pd [RD_LAT];
    logic                  pe [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            pv <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pd[i] <= '0;
                pe[i] <= 1'b0;
            end
        end else begin
            pv[0] <= rd_acc;
            if (rd_acc) begin
                pd[0] <= rd_word;
                pe[0] <= ~in_range;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) begin
                    pd[i] <= pd[i-1];
                    pe[i] <= pe[i-1];
                end
            end
        end
    end

    assign r_valid = pv[RD_LAT-1];
    assign r_data  = pd[RD_LAT-1];
    assign r_err   = pe[RD_LAT-1];

    // ------------------------------------------------------------------
    // Per-layer statistics
    // ------------------------------------------------------------------
`ifdef C2C_RESP_STATS_EN
    logic [CNT_WIDTH-1:0] wr_live;
    logic [CNT_WIDTH-1:0] rd_live;
    logic [CNT_WIDTH-1:0] wr_next;
    logic [CNT_WIDTH-1:0] rd_next;

    // Saturating increments; the result includes this cycle's request so
    // a layer_done coincident with a req captures it.
    always_comb begin
        wr_next = wr_live;
        rd_next = rd_live;
        if (wr_acc && !(&wr_live)) begin
            wr_next = wr_live + CNT_WIDTH'(1);
        end
        if (rd_acc && !(&rd_live)) begin
            rd_next = rd_live + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_live  <= '0;
            rd_live  <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else if (layer_done) begin
            wr_cnt_q <= wr_next;
            rd_cnt_q <= rd_next;
            wr_live  <= '0;
            rd_live  <= '0;
        end else begin
            wr_live <= wr_next;
            rd_live <= rd_next;
        end
    end
`else
    logic unused_stats;

    assign unused_stats = layer_done;
    assign wr_cnt_q     = '0;
    assign rd_cnt_q     = '0;
`endif

endmodule

// File: tb/tb_c2c_resp.sv
// tb_c2c_resp: randomized scoreboard bench for c2c_resp.
// Driver updates a word-level memory model; monitor checks every cycle.

module tb_c2c_resp;

    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1024;
`ifdef C2C_RESP_STATS_EN
    localparam int CW    = 4;
    localparam bit STATS = 1'b1;
`else
    localparam int CW    = 16;
    localparam bit STATS = 1'b0;
`endif
    localparam int MAXC = (1 << CW) - 1;

    typedef struct {
        int          cyc;
        logic [31:0] d;
        logic        e;
    } rd_t;

    typedef struct {
        int cyc;
        int wr;
        int rd;
    } st_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [31:0]   addr = '0;
    logic [31:0]   data = '0;
    logic [3:0]    be = '0;
    logic          we = 1'b0;
    logic          layer_done = 1'b0;
    logic          r_valid;
    logic [31:0]   r_data;
    logic          r_err;
    logic          w_err;
    logic [CW-1:0] wr_cnt_q;
    logic [CW-1:0] rd_cnt_q;

    c2c_resp #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .DEPTH     (DEPTH),
        .RD_LAT    (RD_LAT),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .addr      (addr),
        .data      (data),
        .be        (be),
        .we        (we),
        .layer_done(layer_done),
        .r_valid   (r_valid),
        .r_data    (r_data),
        .r_err     (r_err),
        .w_err     (w_err),
        .wr_cnt_q  (wr_cnt_q),
        .rd_cnt_q  (rd_cnt_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] m [int unsigned];
    rd_t rq[$];
    int  weq[$];
    st_t sq[$];
    int  wr_live = 0;
    int  rd_live = 0;
    int  rst_cyc = -1;
    bit  armed = 1'b0;

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, a, e);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    task automatic drive(input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b,
                         input bit ld, input bit rs);
        int          c;
        int unsigned idx;
        bit          oor;
        logic [31:0] v;
        rd_t         e;
        st_t         s;
        @(negedge clk);
        c = cyc;
        rst = rs;
        req = r;
        we = w;
        addr = a;
        data = d;
        be = b;
        layer_done = ld;
        if (rs) begin
            while (rq.size() > 0 && rq[$].cyc >= c + 1) void'(rq.pop_back());
            while (weq.size() > 0 && weq[$] >= c + 1) void'(weq.pop_back());
            wr_live = 0;
            rd_live = 0;
            s = '{c + 1, 0, 0};
            sq.push_back(s);
            rst_cyc = c + 1;
            return;
        end
        if (r) begin
            idx = a / 4;
            oor = (idx >= DEPTH);
            if (w) begin
                wr_live = sat(wr_live);
                if (oor) begin
                    if (b != 0) weq.push_back(c + 1);
                end else begin
                    v = m.exists(idx) ? m[idx] : 32'h0;
                    for (int k = 0; k < 4; k++)
                        if (b[k]) v[8*k +: 8] = d[8*k +: 8];
                    m[idx] = v;
                end
            end else begin
                rd_live = sat(rd_live);
                e = '{c + RD_LAT, oor ? 32'h0 : m[idx], oor};
                rq.push_back(e);
            end
        end
        if (ld) begin
            s = '{c + 1, STATS ? wr_live : 0, STATS ? rd_live : 0};
            sq.push_back(s);
            wr_live = 0;
            rd_live = 0;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b);
        drive(1, 1, a, d, b, 0, 0);
    endtask

    task automatic rd(input logic [31:0] a);
        drive(1, 0, a, $urandom, $urandom, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(0, $urandom_range(0, 1), $urandom, $urandom, $urandom, 0, 0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] w;
        w = 32'($urandom_range(0, 15)) << 2;
        case ($urandom_range(0, 9))
            0: return 32'h1000 + w;
            1: return 32'h8000_0000 | w;
            2: return 32'hFFC | 32'($urandom_range(0, 3));
            default: return w | 32'($urandom_range(0, 3));
        endcase
    endfunction

    // Monitor / scoreboard
    int exp_wr = 0;
    int exp_rd = 0;
    logic [31:0] last_d = '0;
    logic        last_e = 1'b0;
    always @(negedge clk) begin
        bit ew;
        if (armed) begin
            while (sq.size() > 0 && sq[0].cyc <= cyc) begin
                exp_wr = sq[0].wr;
                exp_rd = sq[0].rd;
                void'(sq.pop_front());
            end
            if (cyc == rst_cyc) begin
                last_d = '0;
                last_e = 1'b0;
            end
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                chk("rd_missing", 64'(r_valid), 64'(1));
                void'(rq.pop_front());
            end
            if (r_valid) begin
                if (rq.size() > 0 && rq[0].cyc == cyc) begin
                    chk("r_data", 64'(r_data), 64'(rq[0].d));
                    chk("r_err", 64'(r_err), 64'(rq[0].e));
                    last_d = rq[0].d;
                    last_e = rq[0].e;
                    void'(rq.pop_front());
                end else begin
                    chk("rd_spurious", 64'(r_valid), 64'(0));
                end
            end else begin
                chk("r_data_hold", 64'(r_data), 64'(last_d));
                chk("r_err_hold", 64'(r_err), 64'(last_e));
            end
            ew = (weq.size() > 0 && weq[0] == cyc);
            if (ew) void'(weq.pop_front());
            chk("w_err", 64'(w_err), 64'(ew));
            chk("wr_cnt_q", 64'(wr_cnt_q), 64'(exp_wr));
            chk("rd_cnt_q", 64'(rd_cnt_q), 64'(exp_rd));
        end
    end

    initial begin
        bit prev_rs;
        repeat (3) @(negedge clk);
        chk("rst_r_valid", 64'(r_valid), 64'(0));
        chk("rst_r_data", 64'(r_data), 64'(0));
        chk("rst_r_err", 64'(r_err), 64'(0));
        chk("rst_w_err", 64'(w_err), 64'(0));
        chk("rst_wr_cnt", 64'(wr_cnt_q), 64'(0));
        chk("rst_rd_cnt", 64'(rd_cnt_q), 64'(0));
        armed = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);

        // Preload every word the stimulus can read
        for (int i = 0; i < 16; i++) wr(32'(i) << 2, $urandom, 4'hF);
        wr(32'hFFC, $urandom, 4'hF);
        drive(0, 0, 0, 0, 0, 1, 0);

        // Full write then read
        wr(32'h10, 32'hDEAD_BEEF, 4'hF);
        rd(32'h10);
        // Byte enables
        wr(32'h20, 32'h1122_3344, 4'hF);
        wr(32'h20, 32'hAABB_CCDD, 4'h5);
        rd(32'h20);
        // Pipelined reads
        rd(32'h0);
        rd(32'h4);
        rd(32'h8);
        // Out of range, no aliasing onto low words
        wr(32'h1000, 32'h5555_AAAA, 4'hF);
        rd(32'h1000);
        rd(32'h0);
        wr(32'h8000_0000, 32'h1234_5678, 4'hF);
        rd(32'h8000_0000);
        rd(32'h0);
        rd(32'hFFC);
        // be=0 and ignored low address bits
        wr(32'h14, 32'hFFFF_FFFF, 4'h0);
        rd(32'h17);
        // Read then write same address
        rd(32'h30);
        wr(32'h30, 32'hCAFE_F00D, 4'hF);
        rd(32'h30);
        idle(4);
        // Reset with reads in flight; req during rst is ignored
        rd(32'h10);
        rd(32'h20);
        drive(1, 1, 32'h10, 32'h0BAD_0BAD, 4'hF, 0, 1);
        idle(5);
        rd(32'h10);
        rd(32'h20);
        idle(3);
        // Layer statistics: 5 writes, 3 reads, 4th read with layer_done
        for (int i = 0; i < 5; i++) wr(32'(i) << 2, $urandom, 4'hF);
        for (int i = 0; i < 3; i++) rd(32'(i) << 2);
        drive(1, 0, 32'h4, 0, 0, 1, 0);
        wr(32'h8, $urandom, 4'hF);
        drive(0, 0, 0, 0, 0, 1, 0);
        // Saturation
        for (int i = 0; i < 20; i++) wr(32'h2C, $urandom, 4'hF);
        drive(0, 0, 0, 0, 0, 1, 0);
        idle(3);

        // Randomized traffic
        prev_rs = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            bit rs;
            rs = !prev_rs && ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), pick(),
                  $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 19) == 0, rs);
            prev_rs = rs;
        end
        idle(RD_LAT + 6);
        chk("drain", 64'(rq.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
